inst_d: RTL and testbench

Instruction decode stage: captures the fetched word and PC from `inst_f` in an IF/ID pipeline register, decodes it, reads two operands from the 32×32 register file, and produces the destination, `reg_write` and hazard fields that `inst_f` consumes as `rs_f_id`/`rt_f_id`/`rd_f_id`/`id_dest`/`reg_write_f_id`. It owns the architectural register file, which the writeback stage writes. A sticky halt flag turns everything after HALT into bubbles.

---
 rtl/inst_d_pkg.sv | 63 ++++++
 rtl/inst_d_reg_file.sv | 46 ++++
 rtl/inst_d.sv | 116 +++++++++++
 tb/tb_inst_d.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_d_pkg.sv
// Shared decode-stage types: opcode enum, instruction formats and destination-select helper.
package inst_d_pkg;

  localparam int unsigned NREG    = 32;
  localparam int unsigned RegIdxW = 5;

  typedef enum logic [5:0] {
    OpAdd  = 6'b000000,
    OpAddi = 6'b000001,
    OpSub  = 6'b000010,
    OpSubi = 6'b000011,
    OpMul  = 6'b000100,
    OpMuli = 6'b000101,
    OpOr   = 6'b000110,
    OpOri  = 6'b000111,
    OpAnd  = 6'b001000,
    OpAndi = 6'b001001,
    OpXor  = 6'b001010,
    OpXori = 6'b001011,
    OpLdw  = 6'b001100,
    OpStw  = 6'b001101,
    OpBz   = 6'b001110,
    OpBeq  = 6'b001111,
    OpJr   = 6'b010000,
    OpHalt = 6'b010001
  } opcode_e;

  localparam logic [5:0] HALT_OP = OpHalt;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [10:0] funct;
  } r_fmt_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } i_fmt_t;

  typedef union packed {
    r_fmt_t r;
    i_fmt_t i;
  } inst_t;

  typedef enum logic [1:0] {DestNone, DestRd, DestRt} dest_sel_e;

  function automatic dest_sel_e dest_sel(logic [5:0] op);
    dest_sel_e sel;
    case (op)
      OpAdd, OpSub, OpMul, OpOr, OpAnd, OpXor:         sel = DestRd;
      OpAddi, OpSubi, OpMuli, OpOri, OpAndi, OpXori,
      OpLdw:                                           sel = DestRt;
      default:                                         sel = DestNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/inst_d_reg_file.sv
// Architectural register file: two read ports with write-through bypass, one write port, R0 = 0.
module inst_d_reg_file #(
  parameter int unsigned NREG = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);

  logic [31:0] regs_q [NREG];
  logic [31:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we_i && waddr_i != '0) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass lets decode see the value being written back this cycle.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (we_i && raddr_a_i == waddr_i) rdata_a_o = wdata_i;
    if (raddr_a_i == '0)              rdata_a_o = '0;
    rdata_b_o = regs_q[raddr_b_i];
    if (we_i && raddr_b_i == waddr_i) rdata_b_o = wdata_i;
    if (raddr_b_i == '0)              rdata_b_o = '0;
  end

endmodule

// File: rtl/inst_d.sv
// Decode stage: IF/ID register, field decode, register-file read, sticky halt and decode counter.
module inst_d #(
  parameter int unsigned NREG = inst_d_pkg::NREG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_write,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  output logic [4:0]  rs_f_id,
  output logic [4:0]  rt_f_id,
  output logic [4:0]  rd_f_id,
  output logic [4:0]  id_dest,
  output logic        reg_write_f_id,
  output logic [5:0]  opcode_d,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic [31:0] imm_ext,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic        halt_d,
  output logic [31:0] dec_count
);
  import inst_d_pkg::*;

  inst_t       if_word_q, if_word_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q, halted_d;
  logic [31:0] cnt_q, cnt_d;
  logic        dec_writes;

  always_comb begin
    if_word_d  = if_word_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    if (if_valid_q && if_word_q.r.opcode == HALT_OP && !flush) begin
      halted_d = 1'b1;
    end
    if (flush) begin
      if_valid_d = 1'b0;
      if_word_d  = '0;
    end else if (halted_q) begin
      if_valid_d = 1'b0;
    end else if (!stall) begin
      if_word_d  = instruction;
      if_pc_d    = pc_in;
      if_valid_d = 1'b1;
      cnt_d      = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_word_q  <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if_word_q  <= if_word_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    id_dest    = '0;
    dec_writes = 1'b0;
    case (dest_sel(if_word_q.r.opcode))
      DestRd: begin
        id_dest    = if_word_q.r.rd;
        dec_writes = 1'b1;
      end
      DestRt: begin
        id_dest    = if_word_q.r.rt;
        dec_writes = 1'b1;
      end
      default: ;
    endcase
  end

  assign rs_f_id        = if_word_q.r.rs;
  assign rt_f_id        = if_word_q.r.rt;
  assign rd_f_id        = if_word_q.r.rd;
  assign opcode_d       = if_word_q.r.opcode;
  assign imm_ext        = {{16{if_word_q.i.imm[15]}}, if_word_q.i.imm};
  assign reg_write_f_id = dec_writes & if_valid_q;
  assign pc_d           = if_pc_q;
  assign valid_d        = if_valid_q;
  assign halt_d         = halted_q;
  assign dec_count      = cnt_q;

  inst_d_reg_file #(
    .NREG(NREG)
  ) u_reg_file (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (wb_write),
    .waddr_i  (wb_dest),
    .wdata_i  (wb_data),
    .raddr_a_i(if_word_q.r.rs),
    .raddr_b_i(if_word_q.r.rt),
    .rdata_a_o(rs_val),
    .rdata_b_o(rt_val)
  );

endmodule

// File: tb/tb_inst_d.sv
// Bench for inst_d: vector table, directed corner sequences and randomized traffic vs a model.
module tb_inst_d;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] pc_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_write = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  rs_f_id, rt_f_id, rd_f_id, id_dest;
  logic        reg_write_f_id, valid_d, halt_d;
  logic [5:0]  opcode_d;
  logic [31:0] rs_val, rt_val, imm_ext, pc_d, dec_count;

  inst_d dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .pc_in         (pc_in),
    .stall         (stall),
    .flush         (flush),
    .wb_write      (wb_write),
    .wb_dest       (wb_dest),
    .wb_data       (wb_data),
    .rs_f_id       (rs_f_id),
    .rt_f_id       (rt_f_id),
    .rd_f_id       (rd_f_id),
    .id_dest       (id_dest),
    .reg_write_f_id(reg_write_f_id),
    .opcode_d      (opcode_d),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .imm_ext       (imm_ext),
    .pc_d          (pc_d),
    .valid_d       (valid_d),
    .halt_d        (halt_d),
    .dec_count     (dec_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference state: the decode slot and the register file as plain variables.
  logic [31:0] m_regs [32];
  logic [31:0] m_word, m_pc, m_cnt;
  bit          m_valid, m_halt;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          st;
    bit          fl;
    bit          ev;
    logic [4:0]  ed;
    bit          erw;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_word = '0; m_pc = '0; m_cnt = '0; m_valid = 0; m_halt = 0;
  endtask

  function automatic logic [31:0] opval(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_write && wb_dest == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic check_model();
    int          op;
    logic [4:0]  rs, rt, rd, dst;
    bit          wr;
    op = int'(m_word[31:26]);
    rs = m_word[25:21];
    rt = m_word[20:16];
    rd = m_word[15:11];
    wr = 0;
    dst = 5'd0;
    if (op <= 11) begin
      wr = 1;
      dst = (op % 2 == 0) ? rd : rt;
    end else if (op == 12) begin
      wr = 1;
      dst = rt;
    end
    chk("valid_d", 32'(valid_d), 32'(m_valid));
    chk("opcode_d", 32'(opcode_d), 32'(op));
    chk("rs_f_id", 32'(rs_f_id), 32'(rs));
    chk("rt_f_id", 32'(rt_f_id), 32'(rt));
    chk("rd_f_id", 32'(rd_f_id), 32'(rd));
    chk("id_dest", 32'(id_dest), 32'(dst));
    chk("reg_write_f_id", 32'(reg_write_f_id), 32'(wr && m_valid));
    chk("imm_ext", imm_ext, {{16{m_word[15]}}, m_word[15:0]});
    chk("rs_val", rs_val, opval(rs));
    chk("rt_val", rt_val, opval(rt));
    chk("pc_d", pc_d, m_pc);
    chk("halt_d", 32'(halt_d), 32'(m_halt));
    chk("dec_count", dec_count, m_cnt);
  endtask

  task automatic model_edge();
    bit halt_seen;
    halt_seen = m_valid && m_word[31:26] == 6'd17 && !flush;
    if (wb_write && wb_dest != 5'd0) m_regs[wb_dest] = wb_data;
    if (flush) begin
      m_valid = 0;
      m_word = '0;
    end else if (m_halt) begin
      m_valid = 0;
    end else if (!stall) begin
      m_word = instruction;
      m_pc = pc_in;
      m_valid = 1;
      m_cnt = m_cnt + 32'd1;
    end
    if (halt_seen) m_halt = 1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic st,
                       input logic fl, input logic ww, input logic [4:0] wd,
                       input logic [31:0] wdat);
    instruction = ins; pc_in = pc; stall = st; flush = fl;
    wb_write = ww; wb_dest = wd; wb_data = wdat;
  endtask

  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h00221800, 32'h100, 0, 0, 1, 5'd3,  1, 32'd1};
    tbl[1]  = '{32'h34000000, 32'h104, 0, 0, 1, 5'd0,  0, 32'd2};
    tbl[2]  = '{32'h00221800, 32'h108, 1, 0, 1, 5'd0,  0, 32'd2};
    tbl[3]  = '{32'h00221800, 32'h10C, 1, 0, 1, 5'd0,  0, 32'd2};
    tbl[4]  = '{32'h00221800, 32'h110, 1, 0, 1, 5'd0,  0, 32'd2};
    tbl[5]  = '{32'h00221800, 32'h114, 1, 1, 0, 5'd0,  0, 32'd2};
    tbl[6]  = '{32'h24E50000, 32'h118, 0, 0, 1, 5'd5,  1, 32'd3};
    tbl[7]  = '{32'h30090000, 32'h11C, 0, 0, 1, 5'd9,  1, 32'd4};
    tbl[8]  = '{32'h0800F800, 32'h120, 0, 0, 1, 5'd31, 1, 32'd5};
    tbl[9]  = '{32'hFC211800, 32'h124, 0, 0, 1, 5'd0,  0, 32'd6};
    tbl[10] = '{32'h40000000, 32'h128, 0, 0, 1, 5'd0,  0, 32'd7};

    @(negedge clk);
    do_reset();
    chk("reset_valid", 32'(valid_d), 32'd0);
    chk("reset_count", dec_count, 32'd0);

    // Table: each row is presented at one edge and its decode checked the cycle after.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].instr, tbl[i].pc, tbl[i].st, tbl[i].fl, 1'b0, 5'd0, 32'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(valid_d), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_dest", i), 32'(id_dest), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_rw", i), 32'(reg_write_f_id), 32'(tbl[i].erw));
      chk($sformatf("vec%0d_cnt", i), dec_count, tbl[i].ecnt);
      if (i == 0) begin
        chk("vec0_rs", 32'(rs_f_id), 32'd1);
        chk("vec0_rt", 32'(rt_f_id), 32'd2);
      end
      if (i >= 2 && i <= 4) chk($sformatf("vec%0d_pc_frozen", i), pc_d, 32'h104);
    end

    // Write-through bypass on rs while ADDI R6,R5,-1 sits in decode.
    drive(32'h04A6FFFF, 32'h300, 0, 0, 0, 5'd0, 32'd0);
    tick();
    drive(32'h0, 32'h304, 1, 0, 1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("bypass_rs_val", rs_val, 32'hDEADBEEF);
    chk("bypass_imm", imm_ext, 32'hFFFFFFFF);
    chk("bypass_dest", 32'(id_dest), 32'd6);
    tick();
    drive(32'h0, 32'h308, 1, 0, 0, 5'd0, 32'd0);
    #1;
    chk("stored_rs_val", rs_val, 32'hDEADBEEF);
    tick();

    // R0 stays zero even with a write and a bypass aimed at it.
    drive(32'h00001800, 32'h310, 0, 0, 1, 5'd0, 32'd7);
    tick();
    drive(32'h0, 32'h314, 1, 0, 1, 5'd0, 32'd7);
    #1;
    chk("r0_rs_val", rs_val, 32'd0);
    chk("r0_rt_val", rt_val, 32'd0);
    tick();

    // Halt: HALT held by a stall, flag sets, later loads become bubbles.
    do_reset();
    drive(32'h44000000, 32'h200, 0, 0, 0, 5'd0, 32'd0);
    tick();
    chk("halt_pre", 32'(halt_d), 32'd0);
    drive(32'h00221800, 32'h204, 1, 0, 0, 5'd0, 32'd0);
    tick();
    chk("halt_set", 32'(halt_d), 32'd1);
    for (int i = 0; i < 2; i++) begin
      drive(32'h00221800, 32'h208, 0, 0, 0, 5'd0, 32'd0);
      tick();
      chk("halt_bubble", 32'(valid_d), 32'd0);
      chk("halt_cnt", dec_count, 32'd1);
    end
    do_reset();
    chk("halt_cleared", 32'(halt_d), 32'd0);
    chk("halt_rst_cnt", dec_count, 32'd0);

    // Counter wrap from all-ones.
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    drive(32'h00221800, 32'h400, 0, 0, 0, 5'd0, 32'd0);
    tick();
    chk("count_wrap", dec_count, 32'd0);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      int          r, opsel;
      logic [5:0]  op;
      logic [31:0] w;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset();
      end else begin
        opsel = int'($urandom_range(0, 24));
        if (opsel < 17) op = 6'(opsel);
        else if (opsel == 17) op = 6'd17;
        else op = 6'($urandom_range(18, 63));
        w = {op, 2'b00, 3'($urandom), 2'b00, 3'($urandom), 16'($urandom)};
        drive(w, $urandom, ($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 2) == 1,
              5'($urandom_range(0, 7)), $urandom);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
